// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and FSM state encodings.
// RESET_PC and PROG_END stay per-instance parameters of inst_fetch.
package riscv_pkg;

   localparam int unsigned INST_BYTES = 4;
   localparam int unsigned XLEN_PC    = 32;
   localparam int unsigned IBUF_WIDTH = 2 * XLEN_PC;

   localparam logic [XLEN_PC-1:0] PC_STEP    = XLEN_PC'(INST_BYTES);
   localparam logic [XLEN_PC-1:0] ALIGN_MASK = ~(XLEN_PC'(INST_BYTES) - 1'b1);

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DONE  = 1'b1
   } fetch_state_t;

   // Word-align a byte address; fetch never issues a misaligned PC.
   function automatic logic [XLEN_PC-1:0] align_pc(input logic [XLEN_PC-1:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer of {pc, inst} pairs with push, pop and flush.
// A push while full is accepted only when the head is popped in the same cycle.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned WIDTH = IBUF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full    = (count_q == 2'd2);
      empty   = (count_q == 2'd0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      rd_data = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         // When full, wr_ptr aliases rd_ptr: overwriting the slot being popped is safe.
         if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks PC over [RESET_PC, PROG_END), buffers words in a
// two-entry FIFO toward decode, and honours single-cycle branch redirects.
module inst_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN_PC-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN_PC-1:0] PROG_END = 32'd32
) (
   input  logic               CLK,
   input  logic               RESET_N,
   output logic [XLEN_PC-1:0] PC,
   input  logic [31:0]        INST_CODE,
   output logic [31:0]        IF_INST,
   output logic [XLEN_PC-1:0] IF_PC,
   output logic               IF_VALID,
   input  logic               ID_READY,
   input  logic               BR_TAKEN,
   input  logic [XLEN_PC-1:0] BR_TARGET,
   output logic               FETCH_DONE
);

   localparam logic [XLEN_PC-1:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

   fetch_state_t          state_q;
   logic                  done_q;
   logic [XLEN_PC-1:0]    pc_q;
   logic [XLEN_PC-1:0]    pc_plus;
   logic [XLEN_PC-1:0]    br_pc;
   logic                  in_range;
   logic                  buf_full;
   logic                  buf_empty;
   logic                  pop;
   logic                  push;
   logic [IBUF_WIDTH-1:0] buf_wdata;
   logic [IBUF_WIDTH-1:0] buf_rdata;

   always_comb begin
      pc_plus   = pc_q + PC_STEP;
      br_pc     = align_pc(BR_TARGET);
      in_range  = (pc_q < PROG_END);
      pop       = !buf_empty && ID_READY;
      push      = (state_q == FETCH) && in_range && (!buf_full || pop) && !BR_TAKEN;
      buf_wdata = {pc_q, INST_CODE};
   end

   // A redirect flushes the buffer, so the popped head is simply consumed.
   fetch_fifo #(
      .WIDTH (IBUF_WIDTH)
   ) u_fetch_fifo (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .push    (push),
      .pop     (pop),
      .flush   (BR_TAKEN),
      .wr_data (buf_wdata),
      .rd_data (buf_rdata),
      .full    (buf_full),
      .empty   (buf_empty)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= FETCH;
         done_q  <= 1'b0;
         pc_q    <= RESET_PC_ALIGNED;
      end else if (BR_TAKEN) begin
         state_q <= FETCH;
         done_q  <= 1'b0;
         pc_q    <= br_pc;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (push) begin
                  pc_q <= pc_plus;
                  if (pc_plus >= PROG_END) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end else if (!in_range) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= FETCH;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      PC         = pc_q;
      IF_PC      = buf_rdata[IBUF_WIDTH-1:XLEN_PC];
      IF_INST    = buf_rdata[XLEN_PC-1:0];
      IF_VALID   = !buf_empty;
      FETCH_DONE = done_q;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; SHALL be a parameter.
REQ-002 PROG_END, 32'd32, first byte address not fetched (exclusive bound); SHALL be a parameter.
REQ-003 CLK  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 PC  output  32  byte address driven to INST_MEM.
REQ-006 INST_CODE  input  32  word returned combinationally by INST_MEM for PC in the same cycle.
REQ-007 IF_INST  output  32  instruction presented to decode.
REQ-008 IF_PC  output  32  address of IF_INST.
REQ-009 IF_VALID  output  1  IF_INST/IF_PC valid.
REQ-010 ID_READY  input  1  decode accepts; transfer when IF_VALID && ID_READY.
REQ-011 BR_TAKEN  input  1  redirect request, single-cycle qualifier for BR_TARGET.
REQ-012 BR_TARGET  input  32  redirect byte address.
REQ-013 FETCH_DONE  output  1  high while state is DONE.

Function
REQ-014 States: FETCH, DONE; FSM SHALL use exactly these two states.
REQ-015 Instruction buffer: 2-entry FIFO of {PC, INST_CODE} pairs; IF_INST/IF_PC SHALL be the head entry; IF_VALID = not empty.
REQ-016 Push condition: state FETCH && PC < PROG_END && (not full || pop this cycle) && !BR_TAKEN; on push PC <= PC + 4.
REQ-017 Pop: IF_VALID && ID_READY; push and pop in the same cycle SHALL leave occupancy unchanged, order preserved.
REQ-018 Latency: word at PC captured at edge k SHALL appear with IF_VALID=1 immediately after edge k (1 cycle fetch-to-valid).
REQ-019 Full with no pop: PC SHALL hold, no push, head SHALL stay stable.
REQ-020 FETCH -> DONE on the edge where PC would become >= PROG_END (after last push) or when PC >= PROG_END; in DONE no push, PC holds, buffered entries still drain.
REQ-021 BR_TAKEN at edge k (any state): flush buffer (IF_VALID=0 after edge k), PC <= {BR_TARGET[31:2],2'b00}, state <= FETCH; redirect SHALL override any simultaneous push and the FIFO write of that cycle.
REQ-022 BR_TAKEN with a simultaneous pop: the popped head counts as consumed; nothing from before the redirect SHALL be presented afterwards.
REQ-023 PC arithmetic modulo 2^32; PC[1:0] SHALL always be 00.
REQ-024 Redirect target >= PROG_END: PC loaded, state DONE on the next edge, no push.

Reset
REQ-025 RESET_N low SHALL immediately (no clock) set PC=RESET_PC, empty the buffer, IF_VALID=0, IF_INST=0, IF_PC=0, state FETCH, FETCH_DONE=0.
REQ-026 Reset asserted mid-stream SHALL discard all buffered instructions; first push follows the first rising edge after release.

Structure
REQ-027 Shared package riscv_pkg SHALL hold INST_BYTES=4, XLEN_PC=32, FSM state encodings; RESET_PC/PROG_END stay module parameters.
REQ-028 Buffer SHALL be a sub-module fetch_fifo (2-entry, 64-bit data, push/pop/flush, full/empty).

Verification
REQ-029 Reset release, ID_READY=1, INST_MEM holding 8 words -> IF_PC 0,4,...,28 on 8 consecutive cycles with IF_INST matching memory; then FETCH_DONE=1, IF_VALID=0, PC=32.
REQ-030 ID_READY=0 from reset -> entries PC 0 and 4 buffered, PC holds 8, IF_PC stays 0; ID_READY=1 -> 0,4,8,... with no drop or duplicate.
REQ-031 Buffer full (0,4), BR_TAKEN=1, BR_TARGET=0x10 -> next cycle IF_VALID=0; following cycle IF_PC=16 and IF_INST=mem[16].
REQ-032 In DONE, BR_TAKEN with BR_TARGET=0x04 -> FETCH_DONE=0, IF_PC 4..28 re-fetched, DONE again.
REQ-033 BR_TARGET=0x16 -> PC=0x14; BR_TARGET=0x40 -> no IF_VALID, FETCH_DONE=1.
REQ-034 RESET_N low between clock edges with 2 entries buffered -> IF_VALID=0, PC=0 before the next edge; after release stream restarts at PC 0.
